reg_file_arbiter: RTL and testbench
===================================

# reg_file_arbiter

Two-requester access arbiter and sequencer for the 16 x 32-bit register file (`reg_file`). It accepts whole transactions (up to two operand reads plus one write) from two independent requesters, grants one at a time with round-robin fairness, and drives the register file's `RD`/`WR`/`EN`/select/data pins in a fixed read-then-write sequence. Read data is latched and returned to the granted requester with a one-cycle `done` pulse.

## Interface
- `DW`, 32: data width (register file word).
- `AW`, 4: register select width.
- `RD_LAT`, 1: cycles from `rf_RD` sample edge to valid `rf_Op1`/`rf_Op2`, range 1..7.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `reqN`  in  1  request from requester N (N = 0, 1); held until `doneN`.
- `reN`  in  1  transaction includes reads.
- `weN`  in  1  transaction includes a write.
- `rselN_a`, `rselN_b`  in  AW  read selects.
- `wselN`  in  AW  write select.
- `wdataN`  in  DW  write data.
- `gntN`  out  1  requester N owns the register file.
- `doneN`  out  1  one-cycle completion pulse.
- `rdataN_a`, `rdataN_b`  out  DW  read results, valid while `doneN` = 1.
- `rf_Ip1`  out  DW  to `reg_file.Ip1`.
- `rf_sel_i1`, `rf_sel_o1`, `rf_sel_o2`  out  AW  to register file selects.
- `rf_RD`, `rf_WR`, `rf_EN`  out  1  register file controls.
- `rf_Op1`, `rf_Op2`  in  DW  register file read data.

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: sample `req0`/`req1`. One request: grant it. Both: grant the requester not granted last (`last` register, reset 1, so requester 0 wins first). Grant latches `re`, `we`, selects and `wdata` of the winner; `gntN` set. Next: READ if `re`; else WRITE if `we`; else DONE.
- READ (1 cycle): `rf_RD`=1, `rf_EN`=1, `rf_sel_o1`/`rf_sel_o2` = latched `rsel_a`/`rsel_b`. Next: WAIT.
- WAIT (RD_LAT cycles, 3-bit counter): `rf_EN`=1. On the edge ending the last WAIT cycle, `rf_Op1`/`rf_Op2` are captured into `rdataN_a`/`rdataN_b`. Next: WRITE if `we`, else DONE.
- WRITE (1 cycle): `rf_WR`=1, `rf_EN`=1, `rf_sel_i1`=latched `wsel`, `rf_Ip1`=latched `wdata`. Next: DONE.
- DONE (1 cycle): `doneN`=1 for the granted requester, `rdataN_*` valid. Next: IDLE, where `gntN` clears and `last` updates.
- Reads precede the write: reading and writing the same register returns the old value.
- `rf_RD` and `rf_WR` are never both 1. `rf_EN`=0 in IDLE and DONE.
- Select and data outputs hold their last latched values outside their active states.
- `rdataN_*` hold their values until that requester's next read capture.
- After a write-only or empty transaction, `rdataN_*` are unchanged.
- Requester deasserting `req` mid-transaction is ignored; the transaction completes.
- Reset (any state, any time): state to IDLE, `last`=1, counter 0, every output 0 (all `gnt`, `done`, `rdata`, `rf_*`). An in-flight transaction is aborted and no `done` is issued.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request sampled at edge E0. `gnt` rises after E0.
- Read-only transaction: `done` is high in the cycle after edge E1+RD_LAT, i.e. the cycle after E2 for `RD_LAT`=1.
- Read+write transaction: one cycle later than read-only.
- Write-only transaction: `rf_WR` is high in the cycle after E0; `done` is high in the cycle after E1.
- Empty transaction: `done` is high in the cycle after E0.
- IDLE is re-entered at the edge ending DONE, and the next request is sampled one edge later (one bubble cycle).
- A requester must drop `req` by the edge ending its `done` cycle unless it has a new transaction.

## Test plan
- Reset: hold `rst`=0 with `req0`=1 → all outputs 0. Release → `gnt0` rises one edge later.
- Write-only, requester 0: `wsel0`=0, `wdata0`=32'habcd_efab → `rf_WR`=1 for one cycle with `rf_sel_i1`=0 and `rf_Ip1`=32'habcd_efab. `done0` is high the cycle after. Repeat with `wsel0`=1, `wdata0`=32'h0123_4567.
- Read, requester 1: `rsel1_a`=1, `rsel1_b`=0, `RD_LAT`=1 → one `rf_RD` pulse. `done1` occurs 3 cycles after the sample edge with `rdata1_a`=32'h0123_4567 and `rdata1_b`=32'habcd_efab.
- Read+write on the same register: read reg 1 and write 32'hdead_beef to reg 1 → `rdata_a`=32'h0123_4567 (old value). A following read returns 32'hdead_beef.
- Contention: `req0` and `req1` held continuously → grants alternate 0,1,0,1. `rf_RD` and `rf_WR` are never both 1. One bubble cycle separates transactions.
- Reset mid-WAIT with `RD_LAT`=3 → no `done` pulse, all outputs 0. After release, the pending request is re-granted from IDLE.

Source files
------------

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
//
// Lets two requesters share the 16 x 32-bit register file. Each requester
// issues a whole transaction (up to two operand reads plus one write). The
// transactions are granted one at a time with round-robin fairness. The
// arbiter drives the register file pins in a fixed order: all reads first,
// then the write. Read data is returned to the owner with a one-cycle done
// pulse.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   reqN, reN, weN            request, transaction has reads, has a write (N = 0, 1)
//   rselN_a, rselN_b, wselN   read selects and write select
//   wdataN                    write data
//   gntN, doneN               ownership flag and one-cycle completion pulse
//   rdataN_a, rdataN_b        read results; they hold until the next read for N
//   rf_Ip1, rf_sel_i1         write data and write select to the register file
//   rf_sel_o1, rf_sel_o2      read selects to the register file
//   rf_RD, rf_WR, rf_EN       register file controls
//   rf_Op1, rf_Op2            read data from the register file, RD_LAT cycles after RD
module reg_file_arbiter #(
   parameter int DW     = 32,
   parameter int AW     = 4,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          re0,
   input  logic          we0,
   input  logic [AW-1:0] rsel0_a,
   input  logic [AW-1:0] rsel0_b,
   input  logic [AW-1:0] wsel0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          re1,
   input  logic          we1,
   input  logic [AW-1:0] rsel1_a,
   input  logic [AW-1:0] rsel1_b,
   input  logic [AW-1:0] wsel1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          done0,
   output logic [DW-1:0] rdata0_a,
   output logic [DW-1:0] rdata0_b,
   output logic          gnt1,
   output logic          done1,
   output logic [DW-1:0] rdata1_a,
   output logic [DW-1:0] rdata1_b,
   output logic [DW-1:0] rf_Ip1,
   output logic [AW-1:0] rf_sel_i1,
   output logic [AW-1:0] rf_sel_o1,
   output logic [AW-1:0] rf_sel_o2,
   output logic          rf_RD,
   output logic          rf_WR,
   output logic          rf_EN,
   input  logic [DW-1:0] rf_Op1,
   input  logic [DW-1:0] rf_Op2
);

   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

   // The WAIT counter runs from 0 up to this value, giving RD_LAT cycles in WAIT.
   localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

   state_t        state;
   logic          last;
   logic          owner;
   logic [2:0]    cnt;
   logic          we_q;
   logic [AW-1:0] wsel_q;
   logic [DW-1:0] wdata_q;

   logic          pick_valid;
   logic          pick;
   logic          pick_re;
   logic          pick_we;
   logic [AW-1:0] pick_rsel_a;
   logic [AW-1:0] pick_rsel_b;
   logic [AW-1:0] pick_wsel;
   logic [DW-1:0] pick_wdata;

   // Choose the winner for the IDLE decision. If only one requester is
   // asking, that requester wins. If both are asking, the one that was not
   // served last wins. The winner's transaction fields are then muxed out
   // so that the sequencer can latch them.
   always_comb begin
      pick_valid = req0 | req1;
      pick       = 1'b0;
      if (req0 && req1) begin
         pick = ~last;
      end else if (req1) begin
         pick = 1'b1;
      end
      pick_re     = pick ? re1     : re0;
      pick_we     = pick ? we1     : we0;
      pick_rsel_a = pick ? rsel1_a : rsel0_a;
      pick_rsel_b = pick ? rsel1_b : rsel0_b;
      pick_wsel   = pick ? wsel1   : wsel0;
      pick_wdata  = pick ? wdata1  : wdata0;
   end

   // This is the transaction sequencer. Every output is registered. Each
   // output is loaded on the edge that enters the state where it is used.
   // Select and data pins are loaded only when a read or write actually
   // starts, so they keep their last values otherwise. The write fields are
   // held in we_q, wsel_q and wdata_q because a read+write transaction
   // reaches WRITE only after the read latency has passed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         owner     <= 1'b0;
         cnt       <= 3'd0;
         we_q      <= 1'b0;
         wsel_q    <= '0;
         wdata_q   <= '0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         rdata0_a  <= '0;
         rdata0_b  <= '0;
         rdata1_a  <= '0;
         rdata1_b  <= '0;
         rf_Ip1    <= '0;
         rf_sel_i1 <= '0;
         rf_sel_o1 <= '0;
         rf_sel_o2 <= '0;
         rf_RD     <= 1'b0;
         rf_WR     <= 1'b0;
         rf_EN     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  owner   <= pick;
                  gnt0    <= ~pick;
                  gnt1    <= pick;
                  we_q    <= pick_we;
                  wsel_q  <= pick_wsel;
                  wdata_q <= pick_wdata;
                  if (pick_re) begin
                     state     <= READ;
                     rf_RD     <= 1'b1;
                     rf_EN     <= 1'b1;
                     rf_sel_o1 <= pick_rsel_a;
                     rf_sel_o2 <= pick_rsel_b;
                  end else if (pick_we) begin
                     state     <= WRITE;
                     rf_WR     <= 1'b1;
                     rf_EN     <= 1'b1;
                     rf_sel_i1 <= pick_wsel;
                     rf_Ip1    <= pick_wdata;
                  end else begin
                     state <= DONE;
                     done0 <= ~pick;
                     done1 <= pick;
                  end
               end
            end
            READ: begin
               rf_RD <= 1'b0;
               cnt   <= 3'd0;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == WAIT_LAST) begin
                  cnt <= 3'd0;
                  if (owner) begin
                     rdata1_a <= rf_Op1;
                     rdata1_b <= rf_Op2;
                  end else begin
                     rdata0_a <= rf_Op1;
                     rdata0_b <= rf_Op2;
                  end
                  if (we_q) begin
                     state     <= WRITE;
                     rf_WR     <= 1'b1;
                     rf_sel_i1 <= wsel_q;
                     rf_Ip1    <= wdata_q;
                  end else begin
                     state <= DONE;
                     rf_EN <= 1'b0;
                     done0 <= ~owner;
                     done1 <= owner;
                  end
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            WRITE: begin
               rf_WR <= 1'b0;
               rf_EN <= 1'b0;
               state <= DONE;
               done0 <= ~owner;
               done1 <= owner;
            end
            DONE: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
               last  <= owner;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Testbench for reg_file_arbiter. It uses directed transactions against a
// behavioural register file model. The main instance uses RD_LAT = 1. A
// second instance uses RD_LAT = 3 and is driven only for the reset-mid-WAIT
// scenario.
module tb_reg_file_arbiter;

   localparam logic [31:0] POISON = 32'h5a5a_5a5a;

   logic clk = 1'b0;
   logic rst;
   logic rst3;

   // This is the RD_LAT = 1 instance.
   logic        req0, re0, we0, req1, re1, we1;
   logic [3:0]  rsel0_a, rsel0_b, wsel0, rsel1_a, rsel1_b, wsel1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, done0, gnt1, done1;
   logic [31:0] rdata0_a, rdata0_b, rdata1_a, rdata1_b;
   logic [31:0] rf_Ip1;
   logic [3:0]  rf_sel_i1, rf_sel_o1, rf_sel_o2;
   logic        rf_RD, rf_WR, rf_EN;
   logic [31:0] rf_Op1 = POISON;
   logic [31:0] rf_Op2 = POISON;
   logic [31:0] mem1 [16];

   // This is the RD_LAT = 3 instance. Only requester 0 is ever used.
   logic        l3_req0, l3_re0;
   logic [3:0]  l3_ra, l3_rb;
   logic        l3_gnt0, l3_done0, l3_gnt1, l3_done1;
   logic [31:0] l3_rdata0_a, l3_rdata0_b, l3_rdata1_a, l3_rdata1_b;
   logic [31:0] l3_ip1;
   logic [3:0]  l3_sel_i1, l3_sel_o1, l3_sel_o2;
   logic        l3_rd, l3_wr, l3_en;
   logic [31:0] l3_op1 = POISON;
   logic [31:0] l3_op2 = POISON;
   logic [31:0] l3_pa = POISON;
   logic [31:0] l3_pb = POISON;
   logic [2:0]  l3_cd = 3'd0;

   int error_count = 0;
   int check_count = 0;

   always #5 clk = ~clk;

   reg_file_arbiter #(.DW(32), .AW(4), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .re0(re0), .we0(we0), .rsel0_a(rsel0_a), .rsel0_b(rsel0_b),
      .wsel0(wsel0), .wdata0(wdata0),
      .req1(req1), .re1(re1), .we1(we1), .rsel1_a(rsel1_a), .rsel1_b(rsel1_b),
      .wsel1(wsel1), .wdata1(wdata1),
      .gnt0(gnt0), .done0(done0), .rdata0_a(rdata0_a), .rdata0_b(rdata0_b),
      .gnt1(gnt1), .done1(done1), .rdata1_a(rdata1_a), .rdata1_b(rdata1_b),
      .rf_Ip1(rf_Ip1), .rf_sel_i1(rf_sel_i1), .rf_sel_o1(rf_sel_o1), .rf_sel_o2(rf_sel_o2),
      .rf_RD(rf_RD), .rf_WR(rf_WR), .rf_EN(rf_EN),
      .rf_Op1(rf_Op1), .rf_Op2(rf_Op2)
   );

   reg_file_arbiter #(.DW(32), .AW(4), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst3),
      .req0(l3_req0), .re0(l3_re0), .we0(1'b0), .rsel0_a(l3_ra), .rsel0_b(l3_rb),
      .wsel0(4'd0), .wdata0(32'd0),
      .req1(1'b0), .re1(1'b0), .we1(1'b0), .rsel1_a(4'd0), .rsel1_b(4'd0),
      .wsel1(4'd0), .wdata1(32'd0),
      .gnt0(l3_gnt0), .done0(l3_done0), .rdata0_a(l3_rdata0_a), .rdata0_b(l3_rdata0_b),
      .gnt1(l3_gnt1), .done1(l3_done1), .rdata1_a(l3_rdata1_a), .rdata1_b(l3_rdata1_b),
      .rf_Ip1(l3_ip1), .rf_sel_i1(l3_sel_i1), .rf_sel_o1(l3_sel_o1), .rf_sel_o2(l3_sel_o2),
      .rf_RD(l3_rd), .rf_WR(l3_wr), .rf_EN(l3_en),
      .rf_Op1(l3_op1), .rf_Op2(l3_op2)
   );

   // This models the register file for the RD_LAT = 1 instance. Reads are
   // sampled on the RD edge and their data is valid right after that edge.
   // Writes land on the WR edge.
   initial begin
      for (int i = 0; i < 16; i++) mem1[i] = 32'd0;
   end

   always @(posedge clk) begin
      if (rf_EN && rf_WR) mem1[rf_sel_i1] <= rf_Ip1;
      if (rf_EN && rf_RD) begin
         rf_Op1 <= mem1[rf_sel_o1];
         rf_Op2 <= mem1[rf_sel_o2];
      end
   end

   // This models the register file for the RD_LAT = 3 instance. Register r
   // reads as c0de_000r. The outputs show POISON until two edges after the
   // RD edge, so the data is valid only in time for the third edge.
   always @(posedge clk) begin
      if (l3_en && l3_rd) begin
         l3_pa  <= 32'hc0de_0000 | 32'(l3_sel_o1);
         l3_pb  <= 32'hc0de_0000 | 32'(l3_sel_o2);
         l3_op1 <= POISON;
         l3_op2 <= POISON;
         l3_cd  <= 3'd2;
      end else if (l3_cd != 3'd0) begin
         l3_cd <= l3_cd - 3'd1;
         if (l3_cd == 3'd1) begin
            l3_op1 <= l3_pa;
            l3_op2 <= l3_pb;
         end
      end
   end

   // This compares one observed value with its expected value and reports
   // any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
      end
   endtask

   // This drives the transaction fields of requester n.
   task automatic applyStimulus(input logic n, input logic req, input logic re, input logic we,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [3:0] ws, input logic [31:0] wd);
      if (n) begin
         req1 = req; re1 = re; we1 = we; rsel1_a = ra; rsel1_b = rb; wsel1 = ws; wdata1 = wd;
      end else begin
         req0 = req; re0 = re; we0 = we; rsel0_a = ra; rsel0_b = rb; wsel0 = ws; wdata0 = wd;
      end
   endtask

   // This task is entered on a negedge while the arbiter is in IDLE. It
   // issues one transaction on the RD_LAT = 1 instance and checks the pins
   // cycle by cycle. The expected timeline is: READ at cycle 1, WAIT at
   // cycle 2, WRITE next if present, then DONE. The owner's read data is
   // compared with ea/eb in the done cycle.
   task automatic runTxn(input string tag, input logic n, input logic re, input logic we,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] ws,
                         input logic [31:0] wd, input logic [31:0] ea, input logic [31:0] eb);
      int done_at;
      int wr_at;
      done_at = 1 + (re ? 2 : 0) + (we ? 1 : 0);
      wr_at   = re ? 3 : 1;
      applyStimulus(n, 1'b1, re, we, ra, rb, ws, wd);
      for (int k = 1; k <= done_at; k++) begin
         @(negedge clk);
         checkOutput({tag, "_gnt"}, 64'({gnt1, gnt0}), n ? 64'd2 : 64'd1);
         checkOutput({tag, "_rd"}, 64'(rf_RD), 64'(re && (k == 1)));
         checkOutput({tag, "_wr"}, 64'(rf_WR), 64'(we && (k == wr_at)));
         checkOutput({tag, "_en"}, 64'(rf_EN), 64'(k < done_at));
         checkOutput({tag, "_done"}, 64'({done1, done0}),
                     (k == done_at) ? (n ? 64'd2 : 64'd1) : 64'd0);
         if (re && (k == 1)) begin
            checkOutput({tag, "_sel_o"}, 64'({rf_sel_o1, rf_sel_o2}), 64'({ra, rb}));
         end
         if (we && (k == wr_at)) begin
            checkOutput({tag, "_sel_i1"}, 64'(rf_sel_i1), 64'(ws));
            checkOutput({tag, "_ip1"}, 64'(rf_Ip1), 64'(wd));
         end
      end
      checkOutput({tag, "_rdata_a"}, 64'(n ? rdata1_a : rdata0_a), 64'(ea));
      checkOutput({tag, "_rdata_b"}, 64'(n ? rdata1_b : rdata0_b), 64'(eb));
      applyStimulus(n, 1'b0, re, we, ra, rb, ws, wd);
      @(negedge clk);
      checkOutput({tag, "_idle"}, 64'({gnt1, gnt0, done1, done0}), 64'd0);
   endtask

   // This watchdog stops the run if the main sequence never finishes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int nd;
      int cyc;
      int both_high;
      int order [4];
      bit bubble_due;
      bit seen0;

      rst = 1'b0;
      rst3 = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0);
      l3_req0 = 1'b0; l3_re0 = 1'b0; l3_ra = 4'd0; l3_rb = 4'd0;

      // While reset is held, a pending request must not get through.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 32'habcd_efab);
      repeat (3) @(negedge clk);
      checkOutput("reset_ctrl", 64'({gnt0, gnt1, done0, done1, rf_RD, rf_WR, rf_EN}), 64'd0);
      checkOutput("reset_sel", 64'({rf_sel_i1, rf_sel_o1, rf_sel_o2}), 64'd0);
      checkOutput("reset_ip1", 64'(rf_Ip1), 64'd0);
      checkOutput("reset_rdata0", {rdata0_a, rdata0_b}, 64'd0);
      checkOutput("reset_rdata1", {rdata1_a, rdata1_b}, 64'd0);

      // Release reset while the request is still held. The grant must
      // follow one edge later.
      rst  = 1'b1;
      rst3 = 1'b1;
      runTxn("wr0_r0", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 32'habcd_efab, 32'd0, 32'd0);
      runTxn("wr0_r1", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 32'h0123_4567, 32'd0, 32'd0);
      runTxn("rd1", 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 32'd0, 32'h0123_4567, 32'habcd_efab);
      runTxn("rdwr0_same", 1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 4'd1, 32'hdead_beef,
             32'h0123_4567, 32'habcd_efab);
      runTxn("rd1_after", 1'b1, 1'b1, 1'b0, 4'd1, 4'd1, 4'd0, 32'd0, 32'hdead_beef, 32'hdead_beef);
      runTxn("empty0", 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 4'd7, 32'h1111_1111,
             32'h0123_4567, 32'habcd_efab);
      runTxn("wr1_r2", 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 32'h5555_aaaa,
             32'hdead_beef, 32'hdead_beef);

      // Contention test. Requester 1 was served last, so with both requests
      // held the grants must go 0,1,0,1. Requester 0 reads r0 and r3, and
      // requester 1 writes r3, so requester 0's second read sees the write.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 32'h3333_3333);
      nd = 0; cyc = 0; both_high = 0; bubble_due = 1'b0; seen0 = 1'b0;
      for (int i = 0; i < 4; i++) order[i] = -1;
      while (nd < 4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (rf_RD && rf_WR) both_high++;
         if (bubble_due) begin
            checkOutput("cont_bubble", 64'({gnt1, gnt0}), 64'd0);
            bubble_due = 1'b0;
         end
         if (done0 || done1) begin
            order[nd] = done1 ? 1 : 0;
            nd++;
            bubble_due = 1'b1;
            if (done0) begin
               checkOutput("cont_rdata0_a", 64'(rdata0_a), 64'h0000_0000_abcd_efab);
               checkOutput("cont_rdata0_b", 64'(rdata0_b), seen0 ? 64'h0000_0000_3333_3333 : 64'd0);
               seen0 = 1'b1;
            end
         end
      end
      checkOutput("cont_done_count", 64'(nd), 64'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput("cont_order", 64'(order[i]), 64'(i % 2));
      end
      checkOutput("cont_rd_wr_overlap", 64'(both_high), 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0);
      @(negedge clk);
      checkOutput("cont_final_idle", 64'({gnt1, gnt0, done1, done0}), 64'd0);

      // Reset in the middle of WAIT on the RD_LAT = 3 instance.
      l3_req0 = 1'b1; l3_re0 = 1'b1; l3_ra = 4'd0; l3_rb = 4'd1;
      @(negedge clk);
      checkOutput("l3_read_start", 64'({l3_gnt0, l3_rd, l3_en}), 64'b111);
      @(negedge clk);
      checkOutput("l3_wait", 64'({l3_gnt0, l3_rd, l3_en, l3_done0}), 64'b1010);
      @(negedge clk);
      rst3 = 1'b0;
      #1;
      checkOutput("l3_rst_ctrl", 64'({l3_gnt0, l3_gnt1, l3_done0, l3_done1, l3_rd, l3_wr, l3_en}),
                  64'd0);
      checkOutput("l3_rst_sel", 64'({l3_sel_i1, l3_sel_o1, l3_sel_o2}), 64'd0);
      checkOutput("l3_rst_ip1", 64'(l3_ip1), 64'd0);
      checkOutput("l3_rst_rdata0", {l3_rdata0_a, l3_rdata0_b}, 64'd0);
      checkOutput("l3_rst_rdata1", {l3_rdata1_a, l3_rdata1_b}, 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("l3_rst_no_done", 64'({l3_gnt0, l3_done0}), 64'd0);
      end

      // After the release, the held request is granted again from IDLE. The
      // read takes READ plus three WAIT cycles, and then DONE comes.
      rst3 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checkOutput("l3_regrant_gnt", 64'(l3_gnt0), 64'd1);
         checkOutput("l3_regrant_rd", 64'(l3_rd), 64'(k == 1));
         checkOutput("l3_regrant_en", 64'(l3_en), 64'(k < 5));
         checkOutput("l3_regrant_done", 64'(l3_done0), 64'(k == 5));
      end
      checkOutput("l3_rdata_a", 64'(l3_rdata0_a), 64'h0000_0000_c0de_0000);
      checkOutput("l3_rdata_b", 64'(l3_rdata0_b), 64'h0000_0000_c0de_0001);
      l3_req0 = 1'b0;
      @(negedge clk);
      checkOutput("l3_idle", 64'({l3_gnt0, l3_done0}), 64'd0);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
